// File: rtl/arm_pipelined_cond_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipelined_pkg
// Shared types and constants for the ARM pipelined conditional-execution pipe.
//   cond_t          : the sixteen ARM condition codes (instruction bits [31:28])
//   FLAG_N..FLAG_V  : bit positions of N, Z, C, V inside a 4-bit flags word
//   ctrl_execute_t  : control word held in the Decode/Execute register
// -----------------------------------------------------------------------------
package arm_pipelined_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] FLAGS_RESET = 4'b0000;

    typedef struct packed {
        logic       pc_source;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       no_write;
        logic       branch;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
        cond_t      cond;
    } ctrl_execute_t;

    // An all-zero control word is a bubble: with no enables set the cond
    // field has no effect.
    localparam ctrl_execute_t CTRL_BUBBLE = ctrl_execute_t'(15'b000000000000000);

endpackage

// File: rtl/arm_pipelined_cond_pipe_if.sv
// -----------------------------------------------------------------------------
// arm_pipelined_cond_pipe_if
// Bundles the decode-side control inputs and the stage-gated control outputs
// of arm_pipelined_cond_pipe.
//   master : control unit / datapath side (drives *_Decode, flush, ALU flags)
//   slave  : the conditional pipe itself
// -----------------------------------------------------------------------------
interface arm_pipelined_cond_pipe_if;

    // Decode-stage control word and Execute-stage feedback
    logic       i_PC_Source_Decode;
    logic       i_Reg_Write_Decode;
    logic       i_Mem_Write_Decode;
    logic       i_Mem_To_Reg_Decode;
    logic       i_ALU_Src_Decode;
    logic       i_No_Write_Decode;
    logic       i_Branch_Decode;
    logic [1:0] i_ALU_Control_Decode;
    logic [1:0] i_Flag_Write_Decode;
    logic [3:0] i_Cond_Decode;
    logic       i_Flush_Execute;
    logic [3:0] i_ALU_Flags;

    // Per-stage controls toward datapath and hazard unit
    logic [1:0] o_ALU_Control_Execute;
    logic       o_ALU_Src_Execute;
    logic       o_Mem_To_Reg_Execute;
    logic       o_Branch_Taken_Execute;
    logic       o_Reg_Write_Memory;
    logic       o_Mem_Write_Memory;
    logic       o_Reg_Write_Writeback;
    logic       o_Mem_To_Reg_Writeback;
    logic       o_PC_Source_Writeback;
    logic       o_PC_Source_Pending;
    logic [3:0] o_Flags;

    modport master (
        output i_PC_Source_Decode, i_Reg_Write_Decode, i_Mem_Write_Decode,
               i_Mem_To_Reg_Decode, i_ALU_Src_Decode, i_No_Write_Decode,
               i_Branch_Decode, i_ALU_Control_Decode, i_Flag_Write_Decode,
               i_Cond_Decode, i_Flush_Execute, i_ALU_Flags,
        input  o_ALU_Control_Execute, o_ALU_Src_Execute, o_Mem_To_Reg_Execute,
               o_Branch_Taken_Execute, o_Reg_Write_Memory, o_Mem_Write_Memory,
               o_Reg_Write_Writeback, o_Mem_To_Reg_Writeback,
               o_PC_Source_Writeback, o_PC_Source_Pending, o_Flags
    );

    modport slave (
        input  i_PC_Source_Decode, i_Reg_Write_Decode, i_Mem_Write_Decode,
               i_Mem_To_Reg_Decode, i_ALU_Src_Decode, i_No_Write_Decode,
               i_Branch_Decode, i_ALU_Control_Decode, i_Flag_Write_Decode,
               i_Cond_Decode, i_Flush_Execute, i_ALU_Flags,
        output o_ALU_Control_Execute, o_ALU_Src_Execute, o_Mem_To_Reg_Execute,
               o_Branch_Taken_Execute, o_Reg_Write_Memory, o_Mem_Write_Memory,
               o_Reg_Write_Writeback, o_Mem_To_Reg_Writeback,
               o_PC_Source_Writeback, o_PC_Source_Pending, o_Flags
    );

endinterface

// File: rtl/arm_pipelined_cond_pipe_cond_check.sv
// -----------------------------------------------------------------------------
// arm_pipelined_cond_check
// Purely combinational condition evaluator for the Execute stage.
//   cond       in  4  condition field of the instruction in Execute
//   flags      in  4  architectural {N,Z,C,V} before this instruction
//   flag_write in  2  bit1: N,Z update requested; bit0: C,V update requested
//   cond_ex    out 1  instruction passes its condition
//   flag_en    out 2  flag_write qualified by cond_ex
// -----------------------------------------------------------------------------
module arm_pipelined_cond_check
    import arm_pipelined_pkg::*;
(
    input  cond_t      cond,
    input  logic [3:0] flags,
    input  logic [1:0] flag_write,
    output logic       cond_ex,
    output logic [1:0] flag_en
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic cond_ex_s;

    assign n_s = flags[FLAG_N];
    assign z_s = flags[FLAG_Z];
    assign c_s = flags[FLAG_C];
    assign v_s = flags[FLAG_V];

    // Evaluate the condition code against the current flags.
    always_comb begin
        cond_ex_s = 1'b0;
        case (cond)
            COND_EQ: cond_ex_s = z_s;
            COND_NE: cond_ex_s = ~z_s;
            COND_CS: cond_ex_s = c_s;
            COND_CC: cond_ex_s = ~c_s;
            COND_MI: cond_ex_s = n_s;
            COND_PL: cond_ex_s = ~n_s;
            COND_VS: cond_ex_s = v_s;
            COND_VC: cond_ex_s = ~v_s;
            COND_HI: cond_ex_s = c_s & ~z_s;
            COND_LS: cond_ex_s = ~c_s | z_s;
            COND_GE: cond_ex_s = ~(n_s ^ v_s);
            COND_LT: cond_ex_s = n_s ^ v_s;
            COND_GT: cond_ex_s = ~z_s & ~(n_s ^ v_s);
            COND_LE: cond_ex_s = z_s | (n_s ^ v_s);
            COND_AL: cond_ex_s = 1'b1;
            COND_NV: cond_ex_s = 1'b0;
            default: cond_ex_s = 1'b0;
        endcase
    end

    assign cond_ex = cond_ex_s;
    assign flag_en = flag_write & {2{cond_ex_s}};

endmodule

// File: rtl/arm_pipelined_cond_pipe.sv
// -----------------------------------------------------------------------------
// arm_pipelined_cond_pipe
// Carries the decode control word through the D/E, E/M and M/W registers,
// applies conditional execution in Execute and owns the NZCV flags register.
//   i_CLK    in  1  clock, rising edge
//   i_RESET  in  1  synchronous active-high reset (overrides flush and data)
//   bus      slave modport of arm_pipelined_cond_pipe_if:
//            *_Decode control word, i_Flush_Execute, i_ALU_Flags in;
//            Execute/Memory/Writeback controls, o_PC_Source_Pending and
//            o_Flags out.
// o_Branch_Taken_Execute and o_PC_Source_Pending are combinational from
// registered state (plus PCSrc_D for the pending term); all other outputs
// come straight from registers.
// -----------------------------------------------------------------------------
module arm_pipelined_cond_pipe
    import arm_pipelined_pkg::*;
(
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    arm_pipelined_cond_pipe_if.slave bus
);

    ctrl_execute_t ctrl_d_s;
    ctrl_execute_t ctrl_e_r;

    logic [3:0] flags_r;
    logic [3:0] flags_next_s;

    logic       cond_ex_s;
    logic [1:0] flag_en_s;

    logic pc_source_g_s;
    logic reg_write_g_s;
    logic mem_write_g_s;
    logic branch_taken_s;

    logic reg_write_m_r;
    logic mem_write_m_r;
    logic mem_to_reg_m_r;
    logic pc_source_m_r;

    logic reg_write_w_r;
    logic mem_to_reg_w_r;
    logic pc_source_w_r;

    // Build the next D/E word: a bubble when Execute is flushed.
    always_comb begin
        ctrl_d_s = CTRL_BUBBLE;
        if (bus.i_Flush_Execute) begin
            ctrl_d_s = CTRL_BUBBLE;
        end else begin
            ctrl_d_s.pc_source   = bus.i_PC_Source_Decode;
            ctrl_d_s.reg_write   = bus.i_Reg_Write_Decode;
            ctrl_d_s.mem_write   = bus.i_Mem_Write_Decode;
            ctrl_d_s.mem_to_reg  = bus.i_Mem_To_Reg_Decode;
            ctrl_d_s.alu_src     = bus.i_ALU_Src_Decode;
            ctrl_d_s.no_write    = bus.i_No_Write_Decode;
            ctrl_d_s.branch      = bus.i_Branch_Decode;
            ctrl_d_s.alu_control = bus.i_ALU_Control_Decode;
            ctrl_d_s.flag_write  = bus.i_Flag_Write_Decode;
            ctrl_d_s.cond        = cond_t'(bus.i_Cond_Decode);
        end
    end

    arm_pipelined_cond_check u_cond_check (
        .cond       (ctrl_e_r.cond),
        .flags      (flags_r),
        .flag_write (ctrl_e_r.flag_write),
        .cond_ex    (cond_ex_s),
        .flag_en    (flag_en_s)
    );

    // Gate every side-effecting Execute control with the condition result.
    always_comb begin
        pc_source_g_s  = ctrl_e_r.pc_source & cond_ex_s;
        reg_write_g_s  = ctrl_e_r.reg_write & cond_ex_s & ~ctrl_e_r.no_write;
        mem_write_g_s  = ctrl_e_r.mem_write & cond_ex_s;
        branch_taken_s = ctrl_e_r.branch & cond_ex_s;
    end

    // Merge ALU flags into the architectural flags, N/Z and C/V independently.
    always_comb begin
        flags_next_s = flags_r;
        if (flag_en_s[1]) begin
            flags_next_s[FLAG_N:FLAG_Z] = bus.i_ALU_Flags[FLAG_N:FLAG_Z];
        end else begin
            flags_next_s[FLAG_N:FLAG_Z] = flags_r[FLAG_N:FLAG_Z];
        end
        if (flag_en_s[0]) begin
            flags_next_s[FLAG_C:FLAG_V] = bus.i_ALU_Flags[FLAG_C:FLAG_V];
        end else begin
            flags_next_s[FLAG_C:FLAG_V] = flags_r[FLAG_C:FLAG_V];
        end
    end

    // Architectural flags register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            flags_r <= FLAGS_RESET;
        end else begin
            flags_r <= flags_next_s;
        end
    end

    // D/E, E/M and M/W pipeline registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            ctrl_e_r       <= CTRL_BUBBLE;
            reg_write_m_r  <= 1'b0;
            mem_write_m_r  <= 1'b0;
            mem_to_reg_m_r <= 1'b0;
            pc_source_m_r  <= 1'b0;
            reg_write_w_r  <= 1'b0;
            mem_to_reg_w_r <= 1'b0;
            pc_source_w_r  <= 1'b0;
        end else begin
            ctrl_e_r       <= ctrl_d_s;
            reg_write_m_r  <= reg_write_g_s;
            mem_write_m_r  <= mem_write_g_s;
            mem_to_reg_m_r <= ctrl_e_r.mem_to_reg;
            pc_source_m_r  <= pc_source_g_s;
            reg_write_w_r  <= reg_write_m_r;
            mem_to_reg_w_r <= mem_to_reg_m_r;
            pc_source_w_r  <= pc_source_m_r;
        end
    end

    assign bus.o_ALU_Control_Execute  = ctrl_e_r.alu_control;
    assign bus.o_ALU_Src_Execute      = ctrl_e_r.alu_src;
    assign bus.o_Mem_To_Reg_Execute   = ctrl_e_r.mem_to_reg;
    assign bus.o_Branch_Taken_Execute = branch_taken_s;
    assign bus.o_Reg_Write_Memory     = reg_write_m_r;
    assign bus.o_Mem_Write_Memory     = mem_write_m_r;
    assign bus.o_Reg_Write_Writeback  = reg_write_w_r;
    assign bus.o_Mem_To_Reg_Writeback = mem_to_reg_w_r;
    assign bus.o_PC_Source_Writeback  = pc_source_w_r;
    // Ungated on purpose: fetch stalls on any in-flight PC write, taken or not.
    assign bus.o_PC_Source_Pending    = bus.i_PC_Source_Decode | ctrl_e_r.pc_source
                                        | pc_source_m_r;
    assign bus.o_Flags                = flags_r;

endmodule

// File: tb/tb_arm_pipelined_cond_pipe.sv
module tb_arm_pipelined_cond_pipe;

    typedef struct packed {
        logic       pc;
        logic       rw;
        logic       mw;
        logic       mtr;
        logic       alusrc;
        logic       nw;
        logic       br;
        logic [1:0] aluc;
        logic [1:0] fw;
        logic [3:0] cond;
    } instr_t;

    // exp = {flags[3:0], aluc[1:0], alusrc, mtr_e, br_taken, rw_m, mw_m, rw_w}
    typedef struct packed {
        instr_t     d;
        logic [3:0] alu;
        logic       fl;
        logic       rs;
        logic [11:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    arm_pipelined_cond_pipe_if bus();

    arm_pipelined_cond_pipe dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    instr_t     m_ex;
    instr_t     m_cur_d;
    logic [3:0] m_flags;
    logic [3:0] m_mrec;   // {rw, mw, mtr, pc} of the instruction in Memory
    logic [2:0] m_wrec;   // {rw, mtr, pc} of the instruction in Writeback

    // Condition rules: pairs of codes share a base test, odd code inverts it.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cy;
        logic v;
        logic base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return base ^ c[0];
    endfunction

    function automatic instr_t mk(input logic pc, input logic rw, input logic mw,
                                  input logic mtr, input logic as, input logic nw,
                                  input logic br, input logic [1:0] aluc,
                                  input logic [1:0] fw, input logic [3:0] cond);
        instr_t r;
        r.pc = pc; r.rw = rw; r.mw = mw; r.mtr = mtr; r.alusrc = as;
        r.nw = nw; r.br = br; r.aluc = aluc; r.fw = fw; r.cond = cond;
        return r;
    endfunction

    task automatic model_step(input instr_t d, input logic [3:0] alu,
                              input logic fl, input logic rs);
        logic ce;
        m_cur_d = d;
        if (rs) begin
            m_ex    = '0;
            m_flags = 4'b0000;
            m_mrec  = 4'b0000;
            m_wrec  = 3'b000;
        end else begin
            ce      = cond_ok(m_ex.cond, m_flags);
            m_wrec  = {m_mrec[3], m_mrec[1], m_mrec[0]};
            m_mrec  = {m_ex.rw & ce & !m_ex.nw, m_ex.mw & ce, m_ex.mtr, m_ex.pc & ce};
            if (ce && m_ex.fw[1]) m_flags[3:2] = alu[3:2];
            if (ce && m_ex.fw[0]) m_flags[1:0] = alu[1:0];
            m_ex    = fl ? instr_t'(15'b0) : d;
        end
    endtask

    function automatic logic [14:0] model_obs();
        return {m_ex.aluc, m_ex.alusrc, m_ex.mtr, m_ex.br & cond_ok(m_ex.cond, m_flags),
                m_mrec[3], m_mrec[2], m_wrec[2], m_wrec[1], m_wrec[0],
                m_cur_d.pc | m_ex.pc | m_mrec[0], m_flags};
    endfunction

    function automatic logic [14:0] dut_obs();
        return {bus.o_ALU_Control_Execute, bus.o_ALU_Src_Execute, bus.o_Mem_To_Reg_Execute,
                bus.o_Branch_Taken_Execute, bus.o_Reg_Write_Memory, bus.o_Mem_Write_Memory,
                bus.o_Reg_Write_Writeback, bus.o_Mem_To_Reg_Writeback,
                bus.o_PC_Source_Writeback, bus.o_PC_Source_Pending, bus.o_Flags};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one decode slot, advance one clock, compare everything to the model.
    task automatic cycle(input instr_t d, input logic [3:0] alu,
                         input logic fl, input logic rs);
        rst                      = rs;
        bus.i_PC_Source_Decode   = d.pc;
        bus.i_Reg_Write_Decode   = d.rw;
        bus.i_Mem_Write_Decode   = d.mw;
        bus.i_Mem_To_Reg_Decode  = d.mtr;
        bus.i_ALU_Src_Decode     = d.alusrc;
        bus.i_No_Write_Decode    = d.nw;
        bus.i_Branch_Decode      = d.br;
        bus.i_ALU_Control_Decode = d.aluc;
        bus.i_Flag_Write_Decode  = d.fw;
        bus.i_Cond_Decode        = d.cond;
        bus.i_Flush_Execute      = fl;
        bus.i_ALU_Flags          = alu;
        model_step(d, alu, fl, rs);
        @(posedge clk);
        @(negedge clk);
        check("model", {1'b0, dut_obs()}, {1'b0, model_obs()});
    endtask

    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;
    localparam logic [3:0] NV = 4'b1111;

    vec_t   tbl [22];
    instr_t nop;
    instr_t rnd;
    logic [31:0] rv;
    logic [11:0] got;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        nop = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, EQ);

        // reset (with flush and live decode data)
        tbl[0]  = '{mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,AL), 4'b1111, 1'b1, 1'b1, 12'b0000_00000_000};
        tbl[1]  = '{nop, 4'b0000, 1'b0, 1'b1, 12'b0000_00000_000};
        // AL ALU op reaches Writeback three edges later
        tbl[2]  = '{mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,AL), 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        tbl[3]  = '{nop, 4'b1111, 1'b0, 1'b0, 12'b0000_00000_100};
        tbl[4]  = '{nop, 4'b0000, 1'b0, 1'b0, 12'b0000_00000_001};
        // CMP then BEQ / BNE back to back
        tbl[5]  = '{mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b11,AL), 4'b0000, 1'b0, 1'b0, 12'b0000_01100_000};
        tbl[6]  = '{mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,EQ), 4'b0100, 1'b0, 1'b0, 12'b0100_00001_000};
        tbl[7]  = '{mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,NE), 4'b0000, 1'b0, 1'b0, 12'b0100_00000_000};
        // partial flag writes
        tbl[8]  = '{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,AL), 4'b0000, 1'b0, 1'b0, 12'b0100_00000_000};
        tbl[9]  = '{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,AL), 4'b1111, 1'b0, 1'b0, 12'b1111_00000_000};
        tbl[10] = '{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,AL), 4'b0000, 1'b0, 1'b0, 12'b0011_00000_000};
        tbl[11] = '{nop, 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        // failed EQ: nothing written, flags hold
        tbl[12] = '{mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,EQ), 4'b1111, 1'b0, 1'b0, 12'b0000_00000_000};
        tbl[13] = '{nop, 4'b1111, 1'b0, 1'b0, 12'b0000_00000_000};
        tbl[14] = '{nop, 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        // flushed decode
        tbl[15] = '{mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b11,2'b00,AL), 4'b0000, 1'b1, 1'b0, 12'b0000_00000_000};
        tbl[16] = '{nop, 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        tbl[17] = '{nop, 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        // cond 1111, then NoWrite with flag update
        tbl[18] = '{mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,NV), 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        tbl[19] = '{mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b11,AL), 4'b0000, 1'b0, 1'b0, 12'b0000_00000_000};
        tbl[20] = '{nop, 4'b1010, 1'b0, 1'b0, 12'b1010_00000_000};
        tbl[21] = '{nop, 4'b0000, 1'b0, 1'b0, 12'b1010_00000_000};

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].d, tbl[i].alu, tbl[i].fl, tbl[i].rs);
            got = {bus.o_Flags, bus.o_ALU_Control_Execute, bus.o_ALU_Src_Execute,
                   bus.o_Mem_To_Reg_Execute, bus.o_Branch_Taken_Execute,
                   bus.o_Reg_Write_Memory, bus.o_Mem_Write_Memory, bus.o_Reg_Write_Writeback};
            check($sformatf("row%0d", i), {4'b0000, got}, {4'b0000, tbl[i].exp});
        end

        // Reset while instructions are in flight clears Memory and Writeback.
        cycle(mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,AL), 4'b0000, 1'b0, 1'b0);
        cycle(nop, 4'b1111, 1'b0, 1'b0);
        check("pre_reset_flags", {12'b0, bus.o_Flags}, 16'h000f);
        cycle(nop, 4'b0000, 1'b0, 1'b1);
        check("reset_clears", {9'b0, bus.o_Reg_Write_Memory, bus.o_Mem_Write_Memory,
              bus.o_Reg_Write_Writeback, bus.o_Flags}, 16'h0000);

        // Flush bubbles Execute but leaves E/M untouched.
        cycle(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,AL), 4'b0000, 1'b0, 1'b0);
        cycle(mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,AL), 4'b0000, 1'b1, 1'b0);
        check("flush_keeps_mem", {14'b0, bus.o_Reg_Write_Memory, bus.o_Mem_Write_Memory}, 16'h0002);
        cycle(nop, 4'b0000, 1'b0, 1'b0);
        check("flush_bubble_mem", {14'b0, bus.o_Reg_Write_Memory, bus.o_Reg_Write_Writeback}, 16'h0001);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            rv  = $urandom;
            rnd = rv[14:0];
            cycle(rnd, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
